// File: rtl/crypter_pkg.sv
// Shared types and limits for the decrypt-side byte path.
package crypter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WORD,
    EMIT,
    WAIT_TX,
    DONE
  } state_e;

  // Worst case: 7 residual bits plus a 31-bit chunk, plus one spare.
  localparam int ACC_W     = 39;
  localparam int N_LEN_MIN = 9;
  localparam int N_LEN_MAX = 32;
  localparam int K_W       = 5;

endpackage

// File: rtl/bit_accumulator.sv
// Bit FIFO for k-bit chunks: shift a chunk in on load, consume the top byte on pop.
// Single-cycle update; the owning FSM never loads while cnt >= 8.
module bit_accumulator #(
  parameter int ACC_W = crypter_pkg::ACC_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic        pop,
  input  logic [4:0]  k,
  input  logic [31:0] chunk,
  output logic [7:0]  top_byte,
  output logic        byte_avail
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] shifted;

  // Bits above cnt are stale but never read: extraction is relative to cnt.
  assign shifted    = acc_q >> (cnt_q - 6'd8);
  assign top_byte   = shifted[7:0];
  assign byte_avail = (cnt_q >= 6'd8);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load) begin
      acc_d = (acc_q << k) | {{(ACC_W-32){1'b0}}, chunk};
      cnt_d = cnt_q + {1'b0, k};
    end else if (pop) begin
      cnt_d = cnt_q - 6'd8;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/plain_unpacker.sv
// Repacks k-bit decrypted payload chunks into bytes for the UART, dropping NUL padding.
// tx_start one cycle after word acceptance; word_ready held low until the UART drains every whole byte.
module plain_unpacker #(
  parameter int ACC_W     = crypter_pkg::ACC_W,
  parameter int N_LEN_MIN = crypter_pkg::N_LEN_MIN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  n_len,
  input  logic        word_valid,
  input  logic [31:0] word_in,
  input  logic        last_word,
  output logic        word_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done_tick,
  output logic        busy,
  output logic        done_tick,
  output logic        err
);

  import crypter_pkg::*;

  localparam logic [5:0] N_MIN6 = 6'(N_LEN_MIN);
  localparam logic [5:0] N_MAX6 = 6'(N_LEN_MAX);

  state_e      state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [7:0]  txd_q, txd_d;

  logic        acc_clr, acc_load, acc_pop;
  logic [7:0]  top_byte;
  logic        byte_avail;
  logic [31:0] mask;
  logic [31:0] chunk;
  logic        high_bits_set;
  logic        n_len_ok;
  logic        send_now;

  assign mask          = (32'h1 << k_q) - 32'h1;
  assign chunk         = word_in & mask;
  assign high_bits_set = |(word_in & ~mask);
  assign n_len_ok      = (n_len >= N_MIN6) && (n_len <= N_MAX6);
  assign send_now      = (state_q == EMIT) && byte_avail && (top_byte != 8'h00);

  bit_accumulator #(.ACC_W(ACC_W)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr        (acc_clr),
    .load       (acc_load),
    .pop        (acc_pop),
    .k          (k_q),
    .chunk      (chunk),
    .top_byte   (top_byte),
    .byte_avail (byte_avail)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    last_d   = last_q;
    err_d    = err_q;
    txd_d    = txd_q;
    acc_clr  = 1'b0;
    acc_load = 1'b0;
    acc_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_len_ok) begin
            k_d     = 5'(n_len - 6'd1);
            err_d   = 1'b0;
            acc_clr = 1'b1;
            state_d = WAIT_WORD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_WORD: begin
        if (word_valid) begin
          acc_load = 1'b1;
          last_d   = last_word;
          // Nonzero bits above the payload mean the wrong key was used.
          if (high_bits_set) err_d = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (byte_avail) begin
          acc_pop = 1'b1;
          if (top_byte != 8'h00) begin
            txd_d   = top_byte;
            state_d = WAIT_TX;
          end
        end else if (last_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT_WORD;
        end
      end
      WAIT_TX: begin
        if (tx_done_tick) state_d = EMIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      last_q  <= last_d;
      err_q   <= err_d;
      txd_q   <= txd_d;
    end
  end

  // Outputs decode registered state only; tx_data is held in txd_q during WAIT_TX.
  assign word_ready = (state_q == WAIT_WORD);
  assign tx_start   = send_now;
  assign tx_data    = send_now ? top_byte : txd_q;
  assign busy       = (state_q == WAIT_WORD) || (state_q == EMIT) || (state_q == WAIT_TX);
  assign done_tick  = (state_q == DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_plain_unpacker.sv
// Directed bench for plain_unpacker with a bit-stream reference model and UART responder.
module tb_plain_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  n_len;
  logic        word_valid;
  logic [31:0] word_in;
  logic        last_word;
  logic        word_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done_tick;
  logic        busy;
  logic        done_tick;
  logic        err;

  always #5 clk = ~clk;

  plain_unpacker dut (
    .clk          (clk),
    .rst          (rst_n),
    .start        (start),
    .n_len        (n_len),
    .word_valid   (word_valid),
    .word_in      (word_in),
    .last_word    (last_word),
    .word_ready   (word_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .done_tick    (done_tick),
    .err          (err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          tx_delay = 1;
  logic        outstanding = 1'b0;
  logic [7:0]  held;
  logic [7:0]  exp_q[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  lit_q[$];
  logic [31:0] msg_w[$];
  logic        exp_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // UART stand-in: completes each byte tx_delay cycles after tx_start (minimum 1).
  initial begin
    tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && rst_n) begin
        for (int i = 0; i < tx_delay && rst_n; i++) @(posedge clk);
        if (rst_n) begin
          #1 tx_done_tick = 1'b1;
          @(posedge clk);
          #1 tx_done_tick = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model's expected byte queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 1'b0;
    end else begin
      if (tx_start) begin
        chk("tx_start_while_outstanding", {31'b0, outstanding}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_byte_unexpected: got 0x%0h, expected no byte at %0t", tx_data, $time);
        end else begin
          chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
        end
        tx_log.push_back(tx_data);
        held        = tx_data;
        outstanding = 1'b1;
      end else if (outstanding) begin
        chk("tx_data_stable", {24'b0, tx_data}, {24'b0, held});
        chk("ready_while_outstanding", {31'b0, word_ready}, 32'd0);
        if (tx_done_tick) outstanding = 1'b0;
      end
      if (done_tick) begin
        done_cnt++;
        chk("done_while_outstanding", {31'b0, outstanding}, 32'd0);
      end
    end
  end

  task automatic do_start(input int n);
    @(posedge clk);
    #1 start = 1'b1;
    n_len = 6'(n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Model: concatenate k-bit chunks MSB-first, cut bytes from the front,
  // drop the trailing partial byte and all NULs.
  task automatic run_msg(input int n, input int delay);
    int         k;
    int         dn0;
    int         t;
    int         p;
    int         b;
    logic       bits[$];
    logic [7:0] all_b[$];
    logic [7:0] v;
    logic       exp_ts;
    k       = n - 1;
    exp_err = 1'b0;
    foreach (msg_w[i]) begin
      for (int j = k - 1; j >= 0; j--) bits.push_back(msg_w[i][j]);
      if ((msg_w[i] >> k) != 32'd0) exp_err = 1'b1;
    end
    for (int i = 0; i + 8 <= bits.size(); i += 8) begin
      v = 8'h00;
      for (int j = 0; j < 8; j++) v = {v[6:0], bits[i+j]};
      all_b.push_back(v);
      if (v != 8'h00) exp_q.push_back(v);
    end
    tx_log   = {};
    tx_delay = delay;
    dn0      = done_cnt;
    do_start(n);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("err_cleared_on_start", {31'b0, err}, 32'd0);
    foreach (msg_w[i]) begin
      word_in    = msg_w[i];
      last_word  = (i == msg_w.size() - 1);
      word_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!word_ready && t < 5000) begin
        @(negedge clk);
        t++;
      end
      chk("word_ready_timeout", {31'b0, word_ready}, 32'd1);
      @(posedge clk);
      #1 word_valid = 1'b0;
      last_word = 1'b0;
      @(negedge clk);
      p = (i * k) / 8;
      b = ((i + 1) * k) / 8;
      exp_ts = (b > p) && (all_b[p] != 8'h00);
      chk("tx_start_after_word", {31'b0, tx_start}, {31'b0, exp_ts});
      chk("ready_low_after_word", {31'b0, word_ready}, 32'd0);
    end
    t = 0;
    while (!done_tick && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("done_tick_seen", {31'b0, done_tick}, 32'd1);
    chk("busy_falls_with_done", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("single_done_tick", done_cnt, dn0 + 1);
    chk("all_bytes_sent", exp_q.size(), 32'd0);
    chk("err_final", {31'b0, err}, {31'b0, exp_err});
    chk("log_len", tx_log.size(), lit_q.size());
    foreach (lit_q[i]) begin
      if (i < tx_log.size()) chk("log_byte", {24'b0, tx_log[i]}, {24'b0, lit_q[i]});
    end
    exp_q = {};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_word_ready"}, {31'b0, word_ready}, 32'd0);
    chk({tag, "_tx_start"}, {31'b0, tx_start}, 32'd0);
    chk({tag, "_tx_data"}, {24'b0, tx_data}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done_tick"}, {31'b0, done_tick}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst_n      = 1'b0;
    start      = 1'b0;
    n_len      = 6'd0;
    word_valid = 1'b0;
    word_in    = 32'd0;
    last_word  = 1'b0;
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // k=8, two plain bytes
    msg_w = {32'h41, 32'h42};
    lit_q = {8'h41, 8'h42};
    run_msg(9, 1);

    // k=12, three bytes spread across two words
    msg_w = {32'h414, 32'h243};
    lit_q = {8'h41, 8'h42, 8'h43};
    run_msg(13, 1);

    // trailing NUL padding suppressed
    msg_w = {32'h414, 32'h200};
    lit_q = {8'h41, 8'h42};
    run_msg(13, 2);

    // leading NUL suppressed, no tx_start after the first word
    msg_w = {32'h00, 32'h41};
    lit_q = {8'h41};
    run_msg(9, 1);

    // k=31: 62 bits -> 7 bytes, 6 residual bits discarded
    msg_w = {32'h20A121A2, 32'h115191C0};
    lit_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    run_msg(32, 1);

    // UART backpressure
    msg_w = {32'h414, 32'h243};
    lit_q = {8'h41, 8'h42, 8'h43};
    run_msg(13, 100);

    // wrong key: bit 16 set, bytes still decoded
    msg_w = {32'h00014869};
    lit_q = {8'h48, 8'h69};
    run_msg(17, 1);

    // out-of-range start: err stays set, block stays idle
    do_start(8);
    @(negedge clk);
    chk("bad_nlen8_err", {31'b0, err}, 32'd1);
    chk("bad_nlen8_busy", {31'b0, busy}, 32'd0);
    chk("bad_nlen8_ready", {31'b0, word_ready}, 32'd0);

    msg_w = {32'h5A};
    lit_q = {8'h5A};
    run_msg(9, 1);
    do_start(33);
    @(negedge clk);
    chk("bad_nlen33_err", {31'b0, err}, 32'd1);
    chk("bad_nlen33_busy", {31'b0, busy}, 32'd0);

    // async reset while a byte is outstanding
    exp_q      = {8'h41};
    tx_delay   = 200;
    do_start(13);
    word_in    = 32'h414;
    last_word  = 1'b0;
    word_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!word_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 word_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!outstanding && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_test_byte_outstanding", {31'b0, outstanding}, 32'd1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    exp_q = {};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", {31'b0, busy}, 32'd0);

    msg_w = {32'h5A};
    lit_q = {8'h5A};
    run_msg(9, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
